// File: rtl/duft_hs_pkg.sv
// Purpose : shared types and constants for the multi-channel DUFT ap_ctrl_hs bridge.
// Latency : n/a (package only).
// Backpressure: n/a.
package duft_hs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCAL = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Offsets inside the local test/status region.
  localparam logic [7:0] LOC_SCRATCH = 8'h00;
  localparam logic [7:0] LOC_LOOP    = 8'h01;
  localparam logic [7:0] LOC_ERR     = 8'h02;
  localparam logic [7:0] LOC_CNT     = 8'h03;

  // addr[AW-1:AW-8] value that selects the local region.
  localparam logic [7:0] LOCAL_TAG = 8'hFF;

  // Read data returned for an undecodable address; sliced to DW by users.
  localparam logic [63:0] INVALID_ADDR = '1;

  // err_status bit flagging an undecodable address.
  localparam int ERR_INVALID = 31;

endpackage

// File: rtl/duft_hs_timeout.sv
// Purpose : loadable down-counter guarding a channel request; expire_o fires when it reaches zero.
// Latency : expire_o is combinational from the count and en_i; the count updates one cycle after load/en.
// Backpressure: none; en_i stalls nothing, it only gates counting and expiry.
// Ports: clk_i/rst_ni clock and sync active-low reset; clr_i zeroes the count; load_i loads load_val_i;
//        en_i decrements while nonzero; expire_o = en_i && count == 0.
module duft_hs_timeout #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/duft_hs_mc_bridge.sv
// Purpose : ap_ctrl_hs access port fanning one read/write out to NCH DUFT channels or local registers.
// Latency : local T+2, invalid T+1, channel T+2+k (k = ack delay after ch_req rises), timeout T+TIMEOUT+1.
// Backpressure: one transaction in flight; ap_start is only sampled while ap_idle, channels stall via ch_ack.
// Ports: clk/ap_rst_n clock and sync active-low reset; ap_start/ap_idle/ap_ready/ap_done/ap_return ap_ctrl_hs;
//        addr/wr_data/rd_wr access; ch_req/ch_we/ch_addr/ch_wdata/ch_ack/ch_rdata channel req/ack; err_irq.
module duft_hs_mc_bridge
  import duft_hs_pkg::*;
#(
  parameter int            DW       = 32,
  parameter int            AW       = 32,
  parameter int            NCH      = 4,
  parameter int            CH_SHIFT = 8,
  parameter int            TIMEOUT  = 200,
  parameter logic [DW-1:0] TO_DATA  = 32'hDEADDEAD
) (
  input  logic                clk,
  input  logic                ap_rst_n,
  input  logic                ap_start,
  output logic                ap_idle,
  output logic                ap_ready,
  output logic                ap_done,
  output logic [DW-1:0]       ap_return,
  input  logic [AW-1:0]       addr,
  input  logic [DW-1:0]       wr_data,
  input  logic                rd_wr,
  output logic [NCH-1:0]      ch_req,
  output logic                ch_we,
  output logic [CH_SHIFT-1:0] ch_addr,
  output logic [DW-1:0]       ch_wdata,
  input  logic [NCH-1:0]      ch_ack,
  input  logic [NCH*DW-1:0]   ch_rdata,
  output logic                err_irq
);

  localparam int             CHW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CHW:0]   NCH_W = (CHW+1)'(NCH);
  localparam int             TW    = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0]  BAD_D = INVALID_ADDR[DW-1:0];

  state_e                state_q, state_d;
  logic [7:0]            off_q, off_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic                  rd_q, rd_d;
  logic [CHW-1:0]        idx_q, idx_d;
  logic [DW-1:0]         ret_q, ret_d;
  logic [NCH-1:0]        req_q, req_d;
  logic                  we_q, we_d;
  logic [CH_SHIFT-1:0]   caddr_q, caddr_d;
  logic [DW-1:0]         cwdata_q, cwdata_d;
  logic [DW-1:0]         scratch_q, scratch_d;
  logic [DW-1:0]         err_q, err_d;
  logic [DW-1:0]         cnt_q, cnt_d;
  logic                  irq_q, irq_d;

  logic                  tmr_load, tmr_en, tmr_clr, tmr_expire;

  // Address decode of the live inputs, used only in IDLE.
  logic [CHW-1:0] in_idx;
  logic [AW-1:0]  in_upper;
  logic           in_local, in_chan;
  logic [NCH-1:0] in_onehot;

  assign in_idx    = addr[CH_SHIFT +: CHW];
  assign in_upper  = addr >> (CH_SHIFT + CHW);
  assign in_local  = (addr[AW-1 -: 8] == LOCAL_TAG);
  assign in_chan   = (in_upper == '0) && ({1'b0, in_idx} < NCH_W);
  assign in_onehot = NCH'(1) << in_idx;

  // ch_req_q is one-hot, so this only sees the addressed channel's ack.
  logic ack_hit;
  assign ack_hit = |(ch_ack & req_q);

  duft_hs_timeout #(.W(TW)) u_timeout (
    .clk_i      (clk),
    .rst_ni     (ap_rst_n),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .load_val_i (TW'(TIMEOUT - 1)),
    .en_i       (tmr_en),
    .expire_o   (tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    idx_d     = idx_q;
    ret_d     = ret_q;
    req_d     = req_q;
    we_d      = we_q;
    caddr_d   = caddr_q;
    cwdata_d  = cwdata_q;
    scratch_d = scratch_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    tmr_clr   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ap_start) begin
          off_d   = addr[7:0];
          wdata_d = wr_data;
          rd_d    = rd_wr;
          if (in_local) begin
            state_d = LOCAL;
          end else if (in_chan) begin
            state_d  = ISSUE;
            idx_d    = in_idx;
            req_d    = in_onehot;
            we_d     = ~rd_wr;
            caddr_d  = addr[CH_SHIFT-1:0];
            cwdata_d = wr_data;
            tmr_load = 1'b1;
          end else begin
            state_d            = DONE;
            err_d[ERR_INVALID] = 1'b1;
            if (rd_wr) ret_d = BAD_D;
          end
        end
      end

      LOCAL: begin
        state_d = DONE;
        case (off_q)
          LOC_SCRATCH: if (rd_q) ret_d = scratch_q; else scratch_d = wdata_q;
          LOC_LOOP:    if (rd_q) ret_d = scratch_q;
          LOC_ERR:     if (rd_q) ret_d = err_q; else err_d = err_q & ~wdata_q;
          LOC_CNT:     if (rd_q) ret_d = cnt_q;
          default: begin
            err_d[ERR_INVALID] = 1'b1;
            if (rd_q) ret_d = BAD_D;
          end
        endcase
      end

      ISSUE: begin
        tmr_en = 1'b1;
        // Ack is checked first so an ack on the expiry cycle still completes normally.
        if (ack_hit) begin
          state_d = DONE;
          req_d   = '0;
          tmr_clr = 1'b1;
          if (rd_q) ret_d = ch_rdata[idx_q*DW +: DW];
        end else if (tmr_expire) begin
          state_d      = DONE;
          req_d        = '0;
          tmr_clr      = 1'b1;
          err_d[idx_q] = 1'b1;
          if (rd_q) ret_d = TO_DATA;
        end
      end

      DONE: begin
        state_d = IDLE;
        cnt_d   = cnt_q + 1'b1;
      end

      default: state_d = IDLE;
    endcase

    irq_d = |err_d;
  end

  always_ff @(posedge clk) begin
    if (!ap_rst_n) begin
      state_q   <= IDLE;
      off_q     <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      idx_q     <= '0;
      ret_q     <= '0;
      req_q     <= '0;
      we_q      <= 1'b0;
      caddr_q   <= '0;
      cwdata_q  <= '0;
      scratch_q <= '0;
      err_q     <= '0;
      cnt_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      off_q     <= off_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      idx_q     <= idx_d;
      ret_q     <= ret_d;
      req_q     <= req_d;
      we_q      <= we_d;
      caddr_q   <= caddr_d;
      cwdata_q  <= cwdata_d;
      scratch_q <= scratch_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      irq_q     <= irq_d;
    end
  end

  assign ap_idle   = (state_q == IDLE);
  assign ap_done   = (state_q == DONE);
  assign ap_ready  = (state_q == DONE);
  assign ap_return = ret_q;
  assign ch_req    = req_q;
  assign ch_we     = we_q;
  assign ch_addr   = caddr_q;
  assign ch_wdata  = cwdata_q;
  assign err_irq   = irq_q;

endmodule

// File: tb/tb_duft_hs_mc_bridge.sv
// Purpose : directed self-checking bench for duft_hs_mc_bridge (NCH=4, TIMEOUT=200).
// Latency : inputs driven and outputs sampled on the falling edge; observation k after the sampling edge is cycle T+k.
// Backpressure: channel acks are driven directly by the directed steps.
module tb_duft_hs_mc_bridge;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NCH = 4;
  localparam int CH_SHIFT = 8;
  localparam int TIMEOUT = 200;

  logic                clk = 1'b0;
  logic                ap_rst_n;
  logic                ap_start;
  logic                ap_idle, ap_ready, ap_done;
  logic [DW-1:0]       ap_return;
  logic [AW-1:0]       addr;
  logic [DW-1:0]       wr_data;
  logic                rd_wr;
  logic [NCH-1:0]      ch_req;
  logic                ch_we;
  logic [CH_SHIFT-1:0] ch_addr;
  logic [DW-1:0]       ch_wdata;
  logic [NCH-1:0]      ch_ack;
  logic [NCH*DW-1:0]   ch_rdata;
  logic                err_irq;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  always #5 clk = ~clk;

  duft_hs_mc_bridge #(
    .DW(DW), .AW(AW), .NCH(NCH), .CH_SHIFT(CH_SHIFT),
    .TIMEOUT(TIMEOUT), .TO_DATA(32'hDEADDEAD)
  ) dut (
    .clk(clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_idle(ap_idle),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_return(ap_return), .addr(addr),
    .wr_data(wr_data), .rd_wr(rd_wr), .ch_req(ch_req), .ch_we(ch_we),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_ack(ch_ack), .ch_rdata(ch_rdata),
    .err_irq(err_irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Launch one transaction and wait (bounded) for ap_done; lat = observation index of ap_done.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input logic rd, output int l);
    addr = a; wr_data = d; rd_wr = rd; ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    l = 0;
    for (int i = 1; i <= 400; i++) begin
      if (ap_done) begin
        l = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ap_rst_n = 1'b0; ap_start = 1'b0; addr = '0; wr_data = '0; rd_wr = 1'b0;
    ch_ack = '0;
    ch_rdata = {32'h3333_3333, 32'h0000_721E, 32'h1111_1111, 32'h0000_0000};
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_idle", ap_idle, 1);
    chk("rst_done", ap_done, 0);
    chk("rst_ready", ap_ready, 0);
    chk("rst_return", ap_return, 0);
    chk("rst_req", ch_req, 0);
    chk("rst_we", ch_we, 0);
    chk("rst_addr", ch_addr, 0);
    chk("rst_wdata", ch_wdata, 0);
    chk("rst_irq", err_irq, 0);
    ap_rst_n = 1'b1;
    @(negedge clk);

    // Local loopback
    do_txn(32'hFF00_0000, 32'h7216, 1'b0, lat);
    chk("loc_wr_lat", lat, 2);
    chk("loc_wr_ready", ap_ready, 1);
    chk("loc_wr_ret", ap_return, 0);
    @(negedge clk);
    chk("loc_done_pulse", ap_done, 0);
    chk("loc_idle_after", ap_idle, 1);
    do_txn(32'hFF00_0001, 32'h0, 1'b1, lat);
    chk("loop_lat", lat, 2);
    chk("loop_data", ap_return, 32'h7216);
    @(negedge clk);
    do_txn(32'hFF00_0003, 32'h0, 1'b1, lat);
    chk("cnt_data", ap_return, 2);
    @(negedge clk);

    // Channel read, ch2 acks in cycle T+4 (k = 3)
    addr = 32'h0000_0218; rd_wr = 1'b1; ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    chk("rd_addr", ch_addr, 32'h18);
    chk("rd_we", ch_we, 0);
    chk("rd_idle", ap_idle, 0);
    ch_ack = 4'b0001;            // wrong-channel ack must be ignored
    for (int k = 1; k <= 4; k++) begin
      chk("rd_req", ch_req, 4'b0100);
      chk("rd_nodone", ap_done, 0);
      if (k == 4) ch_ack = 4'b0100;
      else        ch_ack = (k == 1) ? 4'b1011 : 4'b0000;
      if (k < 4) @(negedge clk);
    end
    @(negedge clk);
    ch_ack = '0;
    chk("rd_done", ap_done, 1);
    chk("rd_data", ap_return, 32'h721E);
    chk("rd_req_drop", ch_req, 0);
    @(negedge clk);

    // Channel write, ch1 acks immediately (k = 0)
    addr = 32'h0000_0110; wr_data = 32'h0722; rd_wr = 1'b0; ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    chk("wr_req", ch_req, 4'b0010);
    chk("wr_we", ch_we, 1);
    chk("wr_wdata", ch_wdata, 32'h0722);
    chk("wr_addr", ch_addr, 32'h10);
    ch_ack = 4'b0010;
    @(negedge clk);
    ch_ack = '0;
    chk("wr_done", ap_done, 1);
    chk("wr_ret_kept", ap_return, 32'h721E);
    @(negedge clk);

    // Timeout on channel 3
    do_txn(32'h0000_0300, 32'h0, 1'b1, lat);
    chk("to_lat", lat, TIMEOUT + 1);
    chk("to_data", ap_return, 32'hDEAD_DEAD);
    chk("to_irq", err_irq, 1);
    @(negedge clk);
    do_txn(32'hFF00_0002, 32'h0, 1'b1, lat);
    chk("to_err", ap_return, 32'h8);
    @(negedge clk);
    do_txn(32'hFF00_0002, 32'h8, 1'b0, lat);
    @(negedge clk);
    chk("w1c_irq", err_irq, 0);
    do_txn(32'hFF00_0002, 32'h0, 1'b1, lat);
    chk("w1c_err", ap_return, 32'h0);
    @(negedge clk);

    // Invalid channel index
    do_txn(32'h0000_0500, 32'h0, 1'b1, lat);
    chk("inv_lat", lat, 1);
    chk("inv_data", ap_return, 32'hFFFF_FFFF);
    chk("inv_noreq", ch_req, 0);
    chk("inv_irq", err_irq, 1);
    @(negedge clk);
    do_txn(32'hFF00_0002, 32'h0, 1'b1, lat);
    chk("inv_err", ap_return, 32'h8000_0000);
    @(negedge clk);
    // Nonzero upper bits and an unmapped local offset are invalid too
    do_txn(32'h0100_0200, 32'h0, 1'b1, lat);
    chk("upper_lat", lat, 1);
    @(negedge clk);
    do_txn(32'hFF00_0007, 32'h0, 1'b1, lat);
    chk("badoff_lat", lat, 2);
    chk("badoff_data", ap_return, 32'hFFFF_FFFF);
    @(negedge clk);
    do_txn(32'hFF00_0002, 32'h8000_0000, 1'b0, lat);
    @(negedge clk);
    chk("inv_clr_irq", err_irq, 0);

    // Reset in the middle of a channel-0 request
    addr = 32'h0000_0004; rd_wr = 1'b1; ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    chk("mid_req", ch_req, 4'b0001);
    ap_rst_n = 1'b0;
    @(negedge clk);
    chk("mid_req_drop", ch_req, 0);
    chk("mid_nodone", ap_done, 0);
    ap_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_idle", ap_idle, 1);
      chk("mid_nodone2", ap_done, 0);
    end
    do_txn(32'hFF00_0000, 32'h0, 1'b1, lat);
    chk("mid_scratch", ap_return, 0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
